mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-lite core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath write enables and mux selects, including `PCsrc`/`EPCWr`/`PCWr` consumed by the next-PC logic and the PC register. It also owns the EXL flag and enters the exception vector on an external interrupt request.

---
 rtl/mc_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: sequences FETCH..write-back,
// drives datapath enables/selects, owns the EXL flag and enters the interrupt vector.
`timescale 1ns/1ps
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        IntReq,
  output logic        PCWr,
  output logic [1:0]  PCsrc,
  output logic        EPCWr,
  output logic        RetSel,
  output logic        IRWr,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUsrc,
  output logic [1:0]  ALUop,
  output logic        ExtOp,
  output logic        MemWr,
  output logic        EXL
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MA     = 4'd2,
    MR     = 4'd3,
    MWB    = 4'd4,
    MW     = 4'd5,
    EXE    = 4'd6,
    AWB    = 4'd7,
    BR     = 4'd8,
    JMP    = 4'd9,
    INT    = 4'd10
  } state_t;

  state_t state, next_state;
  logic   exl_q, exl_set, exl_clr;

  logic [5:0] op, funct;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic       is_beq, is_lui, is_j, is_jal, is_eret;
  logic       unused_ir;

  assign op        = instruction[31:26];
  assign funct     = instruction[5:0];
  assign unused_ir = ^instruction[25:6];

  assign is_r    = (op == 6'b000000);
  assign is_addu = is_r && (funct == 6'b100001);
  assign is_subu = is_r && (funct == 6'b100011);
  assign is_jr   = is_r && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_lui  = (op == 6'b001111);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_eret = (op == 6'b010000) && (funct == 6'b011000);

  // Internal (ungated) control values; outputs are forced low while rst is high
  logic       pc_wr, epc_wr, ret_sel, ir_wr, reg_wr, alu_src, ext_op, mem_wr;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_op;
  state_t     completion;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      exl_q <= 1'b0;
    end else begin
      state <= next_state;
      if (exl_set)      exl_q <= 1'b1;
      else if (exl_clr) exl_q <= 1'b0;
    end
  end

  always_comb begin
    next_state = FETCH;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    epc_wr     = 1'b0;
    ret_sel    = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    ext_op     = 1'b0;
    mem_wr     = 1'b0;
    exl_set    = 1'b0;
    exl_clr    = 1'b0;
    // Interrupts are taken only at instruction boundaries and never while EXL is set
    completion = (IntReq && !exl_q) ? INT : FETCH;

    case (state)
      FETCH: begin
        ir_wr      = 1'b1;
        pc_wr      = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (is_lw || is_sw)                            next_state = MA;
        else if (is_addu || is_subu || is_ori || is_lui) next_state = EXE;
        else if (is_beq)                               next_state = BR;
        else if (is_j || is_jal || is_jr || is_eret)   next_state = JMP;
        else                                           next_state = completion;
      end
      MA, MR: begin
        alu_src    = 1'b1;
        ext_op     = 1'b1;
        next_state = (state == MR) ? MWB : (is_lw ? MR : MW);
      end
      MWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
        next_state = completion;
      end
      MW: begin
        mem_wr     = 1'b1;
        alu_src    = 1'b1;
        ext_op     = 1'b1;
        next_state = completion;
      end
      EXE, AWB: begin
        if (is_subu) begin
          alu_op = 2'b01;
        end else if (is_ori) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
        end else if (is_lui) begin
          alu_op  = 2'b11;
          alu_src = 1'b1;
        end
        if (state == AWB) begin
          reg_wr     = 1'b1;
          reg_dst    = is_r ? 2'b01 : 2'b00;
          next_state = completion;
        end else begin
          next_state = AWB;
        end
      end
      BR: begin
        alu_op     = 2'b01;
        pc_wr      = 1'b1;
        pc_src     = 2'b01;
        next_state = completion;
      end
      JMP: begin
        if (is_j || is_jal) begin
          pc_wr  = 1'b1;
          pc_src = 2'b10;
        end
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        if (is_jr || is_eret) begin
          pc_wr  = 1'b1;
          pc_src = 2'b11;
        end
        if (is_eret) begin
          ret_sel = 1'b1;
          exl_clr = 1'b1;
        end
        next_state = completion;
      end
      INT: begin
        pc_wr      = 1'b1;
        pc_src     = 2'b10;
        epc_wr     = 1'b1;
        exl_set    = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  assign PCWr     = pc_wr   & ~rst;
  assign PCsrc    = rst ? 2'b00 : pc_src;
  assign EPCWr    = epc_wr  & ~rst;
  assign RetSel   = ret_sel & ~rst;
  assign IRWr     = ir_wr   & ~rst;
  assign RegWr    = reg_wr  & ~rst;
  assign RegDst   = rst ? 2'b00 : reg_dst;
  assign MemtoReg = rst ? 2'b00 : mem_to_reg;
  assign ALUsrc   = alu_src & ~rst;
  assign ALUop    = rst ? 2'b00 : alu_op;
  assign ExtOp    = ext_op  & ~rst;
  assign MemWr    = mem_wr  & ~rst;
  assign EXL      = exl_q   & ~rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle table of {instruction, IntReq, expected outputs}
// plus hand-written reset and interrupt-pulse sequences.
`timescale 1ns/1ps
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        IntReq = 1'b0;
  logic        PCWr, EPCWr, RetSel, IRWr, RegWr, ALUsrc, ExtOp, MemWr, EXL;
  logic [1:0]  PCsrc, RegDst, MemtoReg, ALUop;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .IntReq(IntReq),
    .PCWr(PCWr), .PCsrc(PCsrc), .EPCWr(EPCWr), .RetSel(RetSel), .IRWr(IRWr),
    .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUsrc(ALUsrc),
    .ALUop(ALUop), .ExtOp(ExtOp), .MemWr(MemWr), .EXL(EXL)
  );

  always #5 clk = ~clk;

  // {PCWr,PCsrc,EPCWr,RetSel,IRWr,RegWr,RegDst,MemtoReg,ALUsrc,ALUop,ExtOp,MemWr,EXL}
  logic [16:0] act;
  assign act = {PCWr, PCsrc, EPCWr, RetSel, IRWr, RegWr, RegDst, MemtoReg,
                ALUsrc, ALUop, ExtOp, MemWr, EXL};

  localparam logic [16:0] L        = 17'd1;
  localparam logic [16:0] O_ZERO   = 17'd0;
  localparam logic [16:0] O_FETCH  = 17'b1_00_0_0_1_0_00_00_0_00_0_0_0;
  localparam logic [16:0] O_AD_AWB = 17'b0_00_0_0_0_1_01_00_0_00_0_0_0;
  localparam logic [16:0] O_SU_EXE = 17'b0_00_0_0_0_0_00_00_0_01_0_0_0;
  localparam logic [16:0] O_SU_AWB = 17'b0_00_0_0_0_1_01_00_0_01_0_0_0;
  localparam logic [16:0] O_OR_EXE = 17'b0_00_0_0_0_0_00_00_1_10_0_0_0;
  localparam logic [16:0] O_OR_AWB = 17'b0_00_0_0_0_1_00_00_1_10_0_0_0;
  localparam logic [16:0] O_LU_EXE = 17'b0_00_0_0_0_0_00_00_1_11_0_0_0;
  localparam logic [16:0] O_LU_AWB = 17'b0_00_0_0_0_1_00_00_1_11_0_0_0;
  localparam logic [16:0] O_MA     = 17'b0_00_0_0_0_0_00_00_1_00_1_0_0;
  localparam logic [16:0] O_MWB    = 17'b0_00_0_0_0_1_00_01_0_00_0_0_0;
  localparam logic [16:0] O_MW     = 17'b0_00_0_0_0_0_00_00_1_00_1_1_0;
  localparam logic [16:0] O_BR     = 17'b1_01_0_0_0_0_00_00_0_01_0_0_0;
  localparam logic [16:0] O_J      = 17'b1_10_0_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] O_JAL    = 17'b1_10_0_0_0_1_10_10_0_00_0_0_0;
  localparam logic [16:0] O_JR     = 17'b1_11_0_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] O_ERET   = 17'b1_11_0_1_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] O_INT    = 17'b1_10_1_0_0_0_00_00_0_00_0_0_0;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_JAL  = 32'h0C000C00;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_J    = 32'h08000100;
  localparam logic [31:0] I_ORI  = 32'h34220005;
  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_ERET = 32'h42000018;
  localparam logic [31:0] I_UNK  = 32'hFC000000;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        irq;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input string n, input logic [31:0] i, input logic q, input logic [16:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.irq = q; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [31:0] i, input logic q, input logic [16:0] e);
    instruction = i;
    IntReq      = q;
    #1 check(name, e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1);
  end

  initial begin
    add("addu_fetch", I_ADDU, 0, O_FETCH);  add("addu_dec", I_ADDU, 0, O_ZERO);
    add("addu_exe",   I_ADDU, 0, O_ZERO);   add("addu_awb", I_ADDU, 0, O_AD_AWB);
    add("lw_fetch", I_LW, 0, O_FETCH); add("lw_dec", I_LW, 0, O_ZERO);
    add("lw_ma",    I_LW, 0, O_MA);    add("lw_mr",  I_LW, 0, O_MA);
    add("lw_mwb",   I_LW, 0, O_MWB);
    add("sw_fetch", I_SW, 0, O_FETCH); add("sw_dec", I_SW, 0, O_ZERO);
    add("sw_ma",    I_SW, 0, O_MA);    add("sw_mw",  I_SW, 0, O_MW);
    add("beq_fetch", I_BEQ, 0, O_FETCH); add("beq_dec", I_BEQ, 0, O_ZERO);
    add("beq_br",    I_BEQ, 0, O_BR);
    add("jal_fetch", I_JAL, 0, O_FETCH); add("jal_dec", I_JAL, 0, O_ZERO);
    add("jal_jmp",   I_JAL, 0, O_JAL);
    add("jr_fetch",  I_JR, 0, O_FETCH);  add("jr_dec", I_JR, 0, O_ZERO);
    add("jr_jmp",    I_JR, 0, O_JR);
    add("subu_fetch", I_SUBU, 0, O_FETCH);  add("subu_dec", I_SUBU, 0, O_ZERO);
    add("subu_exe",   I_SUBU, 0, O_SU_EXE); add("subu_awb", I_SUBU, 0, O_SU_AWB);
    add("lui_fetch", I_LUI, 0, O_FETCH);  add("lui_dec", I_LUI, 0, O_ZERO);
    add("lui_exe",   I_LUI, 0, O_LU_EXE); add("lui_awb", I_LUI, 0, O_LU_AWB);
    add("j_fetch", I_J, 0, O_FETCH); add("j_dec", I_J, 0, O_ZERO);
    add("j_jmp",   I_J, 0, O_J);
    add("unk_fetch", I_UNK, 0, O_FETCH); add("unk_dec", I_UNK, 0, O_ZERO);
    // ori with IntReq held high: INT after AWB, then EXL blocks a second INT
    add("ori_fetch", I_ORI, 1, O_FETCH);  add("ori_dec", I_ORI, 1, O_ZERO);
    add("ori_exe",   I_ORI, 1, O_OR_EXE); add("ori_awb", I_ORI, 1, O_OR_AWB);
    add("ori_int",   I_ORI, 1, O_INT);
    add("exl_fetch", I_ADDU, 1, O_FETCH | L);  add("exl_dec", I_ADDU, 1, L);
    add("exl_exe",   I_ADDU, 1, L);            add("exl_awb", I_ADDU, 1, O_AD_AWB | L);
    add("eret_fetch", I_ERET, 1, O_FETCH | L); add("eret_dec", I_ERET, 1, L);
    add("eret_jmp",   I_ERET, 1, O_ERET | L);
    add("post_eret_fetch", I_ADDU, 0, O_FETCH); add("post_eret_dec", I_ADDU, 0, O_ZERO);
    add("post_eret_exe",   I_ADDU, 0, O_ZERO);  add("post_eret_awb", I_ADDU, 0, O_AD_AWB);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", O_ZERO);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) step(vecs[k].name, vecs[k].instr, vecs[k].irq, vecs[k].exp);

    // rst asserted during MR: outputs drop at once, FETCH after release
    step("rmr_fetch", I_LW, 0, O_FETCH);
    step("rmr_dec",   I_LW, 0, O_ZERO);
    step("rmr_ma",    I_LW, 0, O_MA);
    instruction = I_LW;
    #1 check("rmr_mr", O_MA);
    #2 rst = 1'b1;
    #1 check("rmr_rst_async", O_ZERO);
    @(negedge clk);
    #1 check("rmr_rst_held", O_ZERO);
    @(negedge clk);
    rst = 1'b0;
    step("rmr_after_fetch", I_LW, 0, O_FETCH);
    step("rmr_after_dec",   I_LW, 0, O_ZERO);
    step("rmr_after_ma",    I_LW, 0, O_MA);
    step("rmr_after_mr",    I_LW, 0, O_MA);
    step("rmr_after_mwb",   I_LW, 0, O_MWB);

    // Unknown opcode with IntReq: INT straight from DECODE, then reset clears EXL
    step("uint_fetch", I_UNK, 1, O_FETCH);
    step("uint_dec",   I_UNK, 1, O_ZERO);
    step("uint_int",   I_UNK, 1, O_INT);
    instruction = I_UNK;
    #1 check("uint_exl_fetch", O_FETCH | L);
    #2 rst = 1'b1;
    #1 check("uint_rst", O_ZERO);
    @(negedge clk);
    rst = 1'b0;
    step("uint_exl_cleared", I_UNK, 0, O_FETCH);
    step("uint_dec2",        I_UNK, 0, O_ZERO);

    // IntReq pulse that misses the completion edge is lost
    step("pulse_fetch", I_UNK, 1, O_FETCH);
    step("pulse_dec",   I_UNK, 0, O_ZERO);
    step("pulse_lost",  I_UNK, 0, O_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
